// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: ALU op codes, response slot states and default widths.
package alu_arb_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;

  // Ops 0-8 produce a data result; ops 9-12 produce a branch decision.
  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    SLL = 4'd2,
    SRL = 4'd3,
    SRA = 4'd4,
    XOR = 4'd5,
    OR  = 4'd6,
    AND = 4'd7,
    LT  = 4'd8,
    BEQ = 4'd9,
    BNE = 4'd10,
    BLT = 4'd11,
    BGE = 4'd12,
    NOP = 4'd15
  } alu_op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester channels, the ALU drive/return signals, the response slot and debug state.
interface alu_share_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
);

  // Handshake rule for req0, req1 and rsp: a beat moves on a cycle where valid && ready;
  // valid never depends on ready, and the payload stays stable while valid waits for ready.
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_branch;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_branch;

  slot_state_e       slot_state;
  logic              prio;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_branch, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_branch,
    output slot_state, prio
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_branch, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_branch,
    input  slot_state, prio
  );

endinterface

// File: rtl/alu_share_arbiter_arb.sv
// Two-way grant logic; round-robin when ALU_ARB_RR_EN is defined, otherwise fixed priority to requester 0.
module alu_rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       en,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       prio_next
);

`ifdef ALU_ARB_RR_EN
  always_comb begin
    grant     = 2'b00;
    prio_next = prio;
    if (valid0 && valid1) begin
      grant = prio ? 2'b10 : 2'b01;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
    // Priority moves to the loser only when a grant actually turns into a transfer.
    if (en && grant[0]) begin
      prio_next = 1'b1;
    end else if (en && grant[1]) begin
      prio_next = 1'b0;
    end
  end
`else
  logic unused_fixed;

  assign grant        = valid0 ? 2'b01 : (valid1 ? 2'b10 : 2'b00);
  assign prio_next    = 1'b0;
  assign unused_fixed = ^{en, prio};
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters and registers its output into a one-entry response slot.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);

  slot_state_e       state_q;
  slot_state_e       state_d;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_branch_q;
  logic              rsp_id_q;
  logic              prio_q;
  logic [1:0]        grant;
  logic              accept_en;
  logic              transfer;

  // Reset blocks acceptance so no ready leaks out while the block is being cleared.
  assign accept_en = !reset && ((state_q == EMPTY) || bus.rsp_ready);
  assign transfer  = accept_en && (grant != 2'b00);

`ifdef ALU_ARB_RR_EN
  logic prio_d;

  alu_rr_arb2 u_arb (
    .valid0    (bus.req0_valid),
    .valid1    (bus.req1_valid),
    .en        (accept_en),
    .prio      (prio_q),
    .grant     (grant),
    .prio_next (prio_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  alu_rr_arb2 u_arb (
    .valid0    (bus.req0_valid),
    .valid1    (bus.req1_valid),
    .en        (accept_en),
    .prio      (prio_q),
    .grant     (grant),
    .prio_next ()
  );

  assign prio_q = 1'b0;
`endif

  assign bus.req0_ready = accept_en && grant[0];
  assign bus.req1_ready = accept_en && grant[1];

  always_comb begin
    bus.alu_op = OP_W'(NOP);
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    if (accept_en && grant[0]) begin
      bus.alu_op = bus.req0_op;
      bus.alu_a  = bus.req0_a;
      bus.alu_b  = bus.req0_b;
    end else if (accept_en && grant[1]) begin
      bus.alu_op = bus.req1_op;
      bus.alu_a  = bus.req1_a;
      bus.alu_b  = bus.req1_b;
    end
  end

  // A new transfer refills the slot even while it drains, so FULL persists at full throughput.
  always_comb begin
    state_d = state_q;
    if (transfer) begin
      state_d = FULL;
    end else if ((state_q == FULL) && bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      rsp_data_q   <= '0;
      rsp_branch_q <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        rsp_data_q   <= bus.alu_result;
        rsp_branch_q <= bus.alu_branch;
        rsp_id_q     <= grant[1];
      end
    end
  end

  assign bus.rsp_valid  = (state_q == FULL);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_branch = rsp_branch_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.slot_state = state_q;
  assign bus.prio       = prio_q;

endmodule
